// File: rtl/pe_sequencer_pkg.sv
// Shared widths, FSM state encoding and delta-entry layout for the PE sequencer.
package pe_sequencer_pkg;

  localparam int unsigned BIN_LEN   = 8;
  localparam int unsigned DELTA_LEN = 4;
  localparam int unsigned COUNT_LEN = 4;
  localparam int unsigned ADDR_LEN  = 8;
  localparam int unsigned NUM_LEN   = 8;
  localparam int unsigned ENTRY_LEN = DELTA_LEN + COUNT_LEN;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MULT,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_t;

  // Shift amount in the high field, repeat count in the low field.
  typedef struct packed {
    logic [DELTA_LEN-1:0] shift;
    logic [COUNT_LEN-1:0] count;
  } delta_entry_t;

endpackage

// File: rtl/pe_sequencer_delta_countdown.sv
// Loadable down-counter tracking the shift-add cycles left for the current delta entry.
module delta_countdown
  import pe_sequencer_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic [COUNT_LEN-1:0] value_i,
  input  logic                 dec_i,
  output logic                 last_c
);

  logic [COUNT_LEN-1:0] remaining_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      remaining_q <= '0;
    end else if (load_i) begin
      remaining_q <= value_i;
    end else if (dec_i && (remaining_q != '0)) begin
      remaining_q <= remaining_q - COUNT_LEN'(1);
    end
  end

  assign last_c = (remaining_q == COUNT_LEN'(1));

endmodule

// File: rtl/pe_sequencer.sv
// Per-job controller stepping a processing element through a base multiply and delta shift-adds.
module pe_sequencer
  import pe_sequencer_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 job_valid,
  output logic                 job_ready,
  input  logic [BIN_LEN-1:0]   job_input,
  input  logic [BIN_LEN-1:0]   job_weight,
  input  logic [ADDR_LEN-1:0]  job_base_addr,
  input  logic [NUM_LEN-1:0]   job_num_deltas,
  output logic                 delta_rd_en,
  output logic [ADDR_LEN-1:0]  delta_rd_addr,
  input  logic [ENTRY_LEN-1:0] delta_rd_data,
  output logic                 pe_enable,
  output logic                 pe_mult_enable,
  output logic                 pe_shift_enable,
  output logic                 pe_delta_count_down_restart,
  output logic [BIN_LEN-1:0]   pe_input_val,
  output logic [BIN_LEN-1:0]   pe_weight_val,
  output logic [DELTA_LEN-1:0] pe_delta_val,
  output logic                 w_valid,
  output logic [NUM_LEN-1:0]   w_index,
  output logic                 job_done
);

  state_t                state_q, state_d;
  logic [BIN_LEN-1:0]    input_q, input_d;
  logic [BIN_LEN-1:0]    weight_q, weight_d;
  logic [ADDR_LEN-1:0]   base_q, base_d;
  logic [NUM_LEN-1:0]    num_q, num_d;
  logic [NUM_LEN-1:0]    idx_q, idx_d;
  logic [DELTA_LEN-1:0]  shift_q, shift_d;

  logic                  cnt_load, cnt_dec, cnt_last;
  logic                  advance;
  logic [NUM_LEN-1:0]    next_idx;
  delta_entry_t          entry;

  assign entry = delta_entry_t'(delta_rd_data);

  delta_countdown u_countdown (
    .clock   (clock),
    .reset   (reset),
    .load_i  (cnt_load),
    .value_i (entry.count),
    .dec_i   (cnt_dec),
    .last_c  (cnt_last)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      input_q  <= '0;
      weight_q <= '0;
      base_q   <= '0;
      num_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
    end else begin
      state_q  <= state_d;
      input_q  <= input_d;
      weight_q <= weight_d;
      base_q   <= base_d;
      num_q    <= num_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
    end
  end

  // Next-state and control decode; LOAD reacts to the read data arriving this cycle.
  always_comb begin
    state_d  = state_q;
    input_d  = input_q;
    weight_d = weight_q;
    base_d   = base_q;
    num_d    = num_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    next_idx = idx_q + NUM_LEN'(1);

    job_ready                   = 1'b0;
    delta_rd_en                 = 1'b0;
    delta_rd_addr               = '0;
    pe_enable                   = 1'b0;
    pe_mult_enable              = 1'b0;
    pe_shift_enable             = 1'b0;
    pe_delta_count_down_restart = 1'b0;
    w_valid                     = 1'b0;
    w_index                     = '0;
    job_done                    = 1'b0;
    cnt_load                    = 1'b0;
    cnt_dec                     = 1'b0;
    advance                     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        job_ready = 1'b1;
        if (job_valid) begin
          input_d  = job_input;
          weight_d = job_weight;
          base_d   = job_base_addr;
          num_d    = job_num_deltas;
          idx_d    = '0;
          state_d  = ST_MULT;
        end
      end
      ST_MULT: begin
        pe_enable      = 1'b1;
        pe_mult_enable = 1'b1;
        w_valid        = 1'b1;
        if (num_q != '0) begin
          delta_rd_en   = 1'b1;
          delta_rd_addr = base_q;
          state_d       = ST_LOAD;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_LOAD: begin
        shift_d = entry.shift;
        if (entry.count == '0) begin
          // Zero-count entry: weight unchanged, report the held accumulator.
          w_valid = 1'b1;
          w_index = next_idx;
          advance = 1'b1;
        end else begin
          cnt_load = 1'b1;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        pe_enable                   = 1'b1;
        pe_shift_enable             = 1'b1;
        pe_delta_count_down_restart = 1'b1;
        cnt_dec                     = 1'b1;
        if (cnt_last) begin
          w_valid = 1'b1;
          w_index = next_idx;
          advance = 1'b1;
        end
      end
      ST_DONE: begin
        job_done = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (advance) begin
      idx_d = next_idx;
      if (next_idx < num_q) begin
        delta_rd_en   = 1'b1;
        delta_rd_addr = base_q + ADDR_LEN'(next_idx);
        state_d       = ST_LOAD;
      end else begin
        state_d = ST_DONE;
      end
    end
  end

  assign pe_input_val  = input_q;
  assign pe_weight_val = weight_q;
  assign pe_delta_val  = shift_q;

endmodule
